// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_e         : controller states (idle, running digits, holding result)
//   calc_ndig()     : number of digits processed per operation
//   calc_cnt_w()    : width of the digit counter (at least one bit)
//   digit_divides() : legality check for the WIDTH/DIGIT pair
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned calc_ndig(input int unsigned width,
                                              input int unsigned digit);
        // Guard the division so an illegal DIGIT=0 reaches the explicit check
        return (digit == 0) ? 1 : width / digit;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

    function automatic bit digit_divides(input int unsigned width,
                                         input int unsigned digit);
        return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full-adder cells.
//   x, y   : DIGIT-bit addends
//   ci     : carry into bit 0
//   s      : DIGIT-bit sum
//   co     : carry out of the top bit
//   msb_ci : carry into the top bit (co ^ msb_ci flags signed overflow)
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             msb_ci
);

    logic carry;

    always_comb begin
        carry  = ci;
        s      = '0;
        msb_ci = ci;
        for (int i = 0; i < DIGIT; i++) begin
            // Last iteration leaves the carry entering the top bit here
            msb_ci = carry;
            s[i]   = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, least-significant digit first, with a registered inter-digit carry.
// Optional subtract mode and signed-overflow output under SERIAL_ADDER_SUB_EN.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin [, sub])
//   out_valid / out_ready: result handshake (sum, cout [, ovf])
//   busy                 : high while running or holding a result
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int unsigned CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if (!digit_divides(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_digit_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // partial sum, filled from the MSB end
    logic [WIDTH-1:0] res_q, res_d;     // last completed result
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_msb_ci;
    logic [WIDTH-1:0] acc_shift;
    logic             sub_sel;
    logic             ovf_next;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x      (a_q[DIGIT-1:0]),
        .y      (b_q[DIGIT-1:0]),
        .ci     (carry_q),
        .s      (dig_s),
        .co     (dig_co),
        .msb_ci (dig_msb_ci)
    );

    // New digit enters at the top; after NDIG shifts digit 0 sits at the LSB
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // Signed overflow is only meaningful on the final (most-significant) digit
    assign ovf_next = dig_co ^ dig_msb_ci;

`ifdef SERIAL_ADDER_SUB_EN
    logic ovf_q, ovf_d;
    assign sub_sel = sub;
`else
    logic unused_ovf;
    assign sub_sel    = 1'b0;
    assign unused_ovf = ovf_next;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    // a - b computed as a + ~b + 1
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = dig_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    res_d   = acc_shift;
                    cout_d  = dig_co;
`ifdef SERIAL_ADDER_SUB_EN
                    ovf_d   = ovf_next;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = res_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
module tb_serial_digit_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-bit, one bit per cycle
    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8, busy8;
    logic [7:0] sum8;
    // 16-bit, four bits per cycle
    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, cout16, busy16;
    logic [15:0] sum16;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub8 = 1'b0, sub16 = 1'b0;
    logic ovf8, ovf16;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub8),
        .ovf       (ovf8),
`endif
        .busy      (busy8)
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub16),
        .ovf       (ovf16),
`endif
        .busy      (busy16)
    );

    // Stimulus helpers (drive only; checks live in the test tasks)
    task automatic start8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int guard = 0;
        while (!in_ready8 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready8 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready8); else n_pass++;
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid8); else n_pass++;
        n_checks++; if (sum8 !== 8'h00) $display("FAIL reset_sum got %h exp 00", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL reset_cout got %b exp 0", cout8); else n_pass++;
        n_checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy8); else n_pass++;
        n_checks++; if (sum16 !== 16'h0000) $display("FAIL reset_sum16 got %h exp 0000", sum16); else n_pass++;
    endtask

    task automatic test_add_basic();
        int lat;
        start8(8'h5A, 8'h33, 1'b0);
        n_checks++; if (busy8 !== 1'b1) $display("FAIL basic_busy_run got %b exp 1", busy8); else n_pass++;
        n_checks++; if (in_ready8 !== 1'b0) $display("FAIL basic_in_ready_run got %b exp 0", in_ready8); else n_pass++;
        wait8(lat);
        n_checks++; if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else n_pass++;
        n_checks++; if (sum8 !== 8'h8D) $display("FAIL basic_sum got %h exp 8d", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL basic_cout got %b exp 0", cout8); else n_pass++;
        consume8();
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL basic_consume_valid got %b exp 0", out_valid8); else n_pass++;
    endtask

    task automatic test_carry();
        int lat;
        start8(8'hFF, 8'h01, 1'b0);
        wait8(lat);
        n_checks++; if (sum8 !== 8'h00) $display("FAIL carry1_sum got %h exp 00", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b1) $display("FAIL carry1_cout got %b exp 1", cout8); else n_pass++;
        consume8();
        start8(8'hFF, 8'hFF, 1'b1);
        wait8(lat);
        n_checks++; if (sum8 !== 8'hFF) $display("FAIL carry2_sum got %h exp ff", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b1) $display("FAIL carry2_cout got %b exp 1", cout8); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL carry2_latency got %0d exp 8", lat); else n_pass++;
        consume8();
    endtask

    task automatic test_backpressure();
        int lat;
        // 0x12 + 0x34 + 1 = 0x47
        start8(8'h12, 8'h34, 1'b1);
        wait8(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
            @(posedge clk); #1;
            n_checks++; if (out_valid8 !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid8); else n_pass++;
            n_checks++; if (sum8 !== 8'h47) $display("FAIL bp_sum[%0d] got %h exp 47", i, sum8); else n_pass++;
            n_checks++; if (cout8 !== 1'b0) $display("FAIL bp_cout[%0d] got %b exp 0", i, cout8); else n_pass++;
            n_checks++; if (in_ready8 !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready8); else n_pass++;
        end
        in_valid8 = 1'b0;
        consume8();
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL bp_after_valid got %b exp 0", out_valid8); else n_pass++;
        n_checks++; if (in_ready8 !== 1'b1) $display("FAIL bp_after_in_ready got %b exp 1", in_ready8); else n_pass++;
        n_checks++; if (busy8 !== 1'b0) $display("FAIL bp_after_busy got %b exp 0", busy8); else n_pass++;
        n_checks++; if (sum8 !== 8'h47) $display("FAIL bp_sum_kept got %h exp 47", sum8); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start8(8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready8 !== 1'b1) $display("FAIL midrst_in_ready got %b exp 1", in_ready8); else n_pass++;
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", out_valid8); else n_pass++;
        n_checks++; if (sum8 !== 8'h00) $display("FAIL midrst_sum got %h exp 00", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL midrst_cout got %b exp 0", cout8); else n_pass++;
        n_checks++; if (busy8 !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy8); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start8(8'h01, 8'h01, 1'b0);
        wait8(lat);
        n_checks++; if (sum8 !== 8'h02) $display("FAIL midrst_fresh_sum got %h exp 02", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b0) $display("FAIL midrst_fresh_cout got %b exp 0", cout8); else n_pass++;
        consume8();
    endtask

    task automatic test_wide();
        int lat;
        logic [15:0] va [2] = '{16'hFFFF, 16'h1234};
        logic [15:0] vb [2] = '{16'h0001, 16'h0FCD};
        logic [15:0] vs [2] = '{16'h0000, 16'h2201};
        logic        vc [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            a16 = va[i]; b16 = vb[i]; cin16 = 1'b0; in_valid16 = 1'b1;
            @(posedge clk); #1;
            in_valid16 = 1'b0;
            lat = 0;
            while (!out_valid16 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            n_checks++; if (lat !== 4) $display("FAIL wide_latency[%0d] got %0d exp 4", i, lat); else n_pass++;
            n_checks++; if (sum16 !== vs[i]) $display("FAIL wide_sum[%0d] got %h exp %h", i, sum16, vs[i]); else n_pass++;
            n_checks++; if (cout16 !== vc[i]) $display("FAIL wide_cout[%0d] got %b exp %b", i, cout16, vc[i]); else n_pass++;
            out_ready16 = 1'b1;
            @(posedge clk); #1;
            out_ready16 = 1'b0;
            n_checks++; if (in_ready16 !== 1'b1) $display("FAIL wide_idle[%0d] got %b exp 1", i, in_ready16); else n_pass++;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        sub8 = 1'b1;
        start8(8'h10, 8'h01, 1'b0);
        wait8(lat);
        n_checks++; if (sum8 !== 8'h0F) $display("FAIL sub1_sum got %h exp 0f", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b1) $display("FAIL sub1_cout got %b exp 1", cout8); else n_pass++;
        n_checks++; if (ovf8 !== 1'b0) $display("FAIL sub1_ovf got %b exp 0", ovf8); else n_pass++;
        consume8();
        start8(8'h80, 8'h01, 1'b0);
        wait8(lat);
        n_checks++; if (sum8 !== 8'h7F) $display("FAIL sub2_sum got %h exp 7f", sum8); else n_pass++;
        n_checks++; if (cout8 !== 1'b1) $display("FAIL sub2_cout got %b exp 1", cout8); else n_pass++;
        n_checks++; if (ovf8 !== 1'b1) $display("FAIL sub2_ovf got %b exp 1", ovf8); else n_pass++;
        consume8();
        sub8 = 1'b0;
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_add_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_wide();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Multi-cycle, parametrised adder. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, least-significant digit first, using a registered carry.
- Successor to the single-bit combinational adder cell. Trades latency for area in wide datapaths.
- Valid/ready handshake on both input and output, so it sits between register stages of the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, (a+b+cin) mod 2^WIDTH
- cout  output  1  carry-out of the MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- NDIG = WIDTH/DIGIT. Counter width CNT_W = max(1, clog2(NDIG)).
- Reset (async, rst_n=0):
  - State forced to IDLE.
  - Operand, sum and carry registers, and counter, cleared to 0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
  - A reset asserted mid-RUN or mid-DONE aborts the operation. No result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b into shift registers; capture cin into the carry register; counter=0; go to RUN.
- RUN:
  - in_ready=0; in_valid ignored.
  - Each cycle: add operand low digits plus carry register, producing a DIGIT-bit result and a carry.
  - Result digit shifts into sum register from the MSB end. Operands shift right by DIGIT. Carry register updates. Counter increments.
  - When counter==NDIG-1 on a RUN edge, go to DONE. Sum register then holds the full result; carry register holds cout.
- DONE:
  - out_valid=1.
  - sum and cout stable, equal to the registered values.
  - On out_ready=1, go to IDLE (out_valid drops next cycle).
  - out_ready=0 holds the result indefinitely; in_ready stays 0.
- Latency: operands accepted at edge T. out_valid first high after edge T+NDIG. Minimum issue interval is NDIG+2 cycles.
- No new operation can be accepted in the same cycle a result is consumed.
- sum/cout are not cleared on consume. They keep the last result until the next DONE.
- Wrap-around: overflow beyond WIDTH appears only on cout.
  - Example: all-ones + all-ones + 1 gives sum=all-ones, cout=1.
- NDIG==1 (DIGIT==WIDTH): one RUN cycle; the counter is unused.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with the operands on accept.
  - When sub=1, b is captured inverted and the carry register is set to 1 (cin ignored). Result is a−b mod 2^WIDTH.
  - cout=1 means no borrow.
  - Additional output ovf (1 bit): signed overflow of the final MSB, valid with out_valid, reset 0.
- Not defined: no sub or ovf ports; addition only.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE)
  - functions computing NDIG and CNT_W
  - DIGIT-divides-WIDTH check helper
- One sub-module: digit_adder.
  - Combinational, parametrised DIGIT, chain of full-adder cells.
  - Inputs x, y (DIGIT), ci.
  - Outputs s (DIGIT), co, plus msb_ci for overflow detection.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0. out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN (after 3 digits) -> all outputs at reset values immediately. A fresh a=0x01, b=0x01 then yields sum=0x02.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, latency 4 cycles.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1, ovf=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, ovf=1.
